// File: rtl/mul_seq_ctrl_if.sv
// Handshake and shared-ALU signal bundle for the sequential multiply controller.
// slave: the controller side; master: the requester/ALU side.
interface mul_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_valid;
  logic                  start_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  kill;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  busy;
  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;

  modport slave (
    input  start_valid, op_a, op_b, kill, res_ready, alu_result,
    output start_ready, res_valid, res_data, busy, alu_A, alu_B, alu_op
  );

  modport master (
    output start_valid, op_a, op_b, kill, res_ready, alu_result,
    input  start_ready, res_valid, res_data, busy, alu_A, alu_B, alu_op
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiply controller borrowing a shared ALU: ADD folds mcand into acc,
// SHIFT doubles mcand and consumes one multiplier bit.
module mul_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           resetn,
  mul_seq_ctrl_if.slave bus
);

  localparam logic [3:0] AluAddu = 4'b0000;
  localparam logic [3:0] AluSll  = 4'b1000;

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;

  logic                  start_ready;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] mplier_shr;

  assign mplier_shr = mplier_q >> 1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = AluAddu;

    unique case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (bus.start_valid) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          if (bus.op_b == '0)   state_d = StDone;
          else if (bus.op_b[0]) state_d = StAdd;
          else                  state_d = StShift;
        end
      end
      StAdd: begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_op  = AluAddu;
        acc_d   = bus.alu_result;
        state_d = StShift;
      end
      StShift: begin
        alu_a    = DATA_WIDTH'(1);
        alu_b    = mcand_q;
        alu_op   = AluSll;
        mcand_d  = bus.alu_result;
        mplier_d = mplier_shr;
        // Look one bit ahead so the next ADD lines up with the bit just exposed.
        if (mplier_shr == '0) state_d = StDone;
        else if (mplier_q[1]) state_d = StAdd;
        else                  state_d = StShift;
      end
      StDone: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Kill discards the operation outright; datapath registers keep their values.
    if (bus.kill) begin
      state_d  = StIdle;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid;
  assign bus.res_data    = acc_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.alu_A       = alu_a;
  assign bus.alu_B       = alu_b;
  assign bus.alu_op      = alu_op;

endmodule
